mem_responder: RTL
==================

# mem_responder

Multi-cycle, word-organised memory responder that serves the processor's data-side load/store requests over a valid/ready request–response handshake. It replaces the always-ready memory model on the data path of the multi-cycle core. It serves one transaction at a time, with a fixed, parameterised access latency, byte-enable writes and an error response for misaligned or out-of-range addresses.

## Interface
Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words stored; legal word index 0..DEPTH_WORDS-1
- LATENCY, 2, WAIT cycles between acceptance and access commit; legal range 1..15

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  requester presents a request
- req_ready  out  1  responder can accept; high only in IDLE
- req_wr  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_be  in  4  byte enables for stores; bit i enables byte lane i; ignored for loads
- resp_valid  out  1  response available
- resp_ready  in  1  requester accepts the response
- resp_rdata  out  32  load data; 0 for stores and errors
- resp_err  out  1  request was misaligned or out of range

## Operation
- FSM states are IDLE, WAIT and RESP.
- **IDLE**
  - req_ready=1.
  - When req_valid&&req_ready at an edge, latch req_wr, req_addr, req_wdata and req_be.
  - Load the counter with LATENCY-1 and go to WAIT.
- **WAIT**
  - req_ready=0 and resp_valid=0.
  - At each edge with counter≠0, decrement the counter.
  - At the edge with counter==0, perform the access (commit edge) and go to RESP.
- **Access at the commit edge**
  - Error is defined as addr[1:0]≠0 or addr[31:2]≥DEPTH_WORDS.
  - Error: no array write; resp_err=1 and resp_rdata=0.
  - Store, no error: write each byte lane whose req_be bit is 1; other lanes are unchanged. resp_rdata=0 and resp_err=0.
  - Store with req_be=0 is legal: nothing is written and the response is normal.
  - Load, no error: resp_rdata = word at addr[31:2]; resp_err=0.
- **RESP**
  - resp_valid=1; resp_rdata and resp_err are held stable.
  - At the edge with resp_ready=1, go to IDLE.
  - resp_ready is ignored in every other state.
- Request inputs are ignored while not in IDLE; latched fields never change mid-transaction.
- Stores become visible to any load accepted after the store's response handshake.
- Array contents are not affected by rst. Unwritten words read as X in simulation.

## Timing
- Reset values: req_ready=1 (state IDLE, one cycle after the reset edge), resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
- Latency: request accepted at edge E0; the commit happens at edge E_LATENCY; resp_valid is high from then until the response handshake edge.
- Minimum occupancy per transaction is LATENCY+2 cycles: the accept cycle, LATENCY WAIT cycles, and at least one RESP cycle.
- Back-to-back operation: the RESP→IDLE edge sets req_ready=1 in the next cycle. A response and the next request are never accepted at the same edge.
- resp_ready held high before RESP causes a single-cycle resp_valid pulse.
- Reset mid-operation: any state returns to IDLE and outputs take their reset values.
  - A store whose commit edge coincides with rst=1 is discarded, because reset wins.
  - A store already committed persists.
- Counter width is 4 bits. LATENCY outside 1..15 is a parameter error, flagged by an elaboration-time check.

## Structure
- Shared package mem_pkg holds:
  - the state enum (IDLE, WAIT, RESP)
  - WORD_W=32 and BE_W=4
  - the error predicate function: misaligned, or word index ≥ depth
- Sub-module mem_array holds the storage: DEPTH_WORDS×32, one port, per-byte write enable, registered read. Its output feeds resp_rdata at the commit edge.
- The top level contains the FSM, the latency counter, the request latches and the response registers.

## Test plan
- Reset then idle: assert rst for 2 cycles → req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0; no spurious responses over 20 idle cycles.
- Store/load round trip, LATENCY=2:
  - Store addr 0x10, data 0xDEADBEEF, be=0xF → resp_valid exactly 2 edges after acceptance, resp_err=0, rdata=0.
  - Load 0x10 → rdata=0xDEADBEEF.
- Byte enables:
  - Store 0x20 = 0x11223344 with be=0xF, then store 0xAABBCCDD with be=0x5.
  - Load 0x20 → 0x11BB33DD.
- Errors, each with resp_err=1 and rdata=0:
  - Load 0x22.
  - Store to byte address 4*DEPTH_WORDS (0x1000) with value V; a later load of 0x0 still returns its prior value, not V.
- Backpressure and ignored inputs:
  - Hold resp_ready=0 for 5 cycles → resp_valid and data stable; req_ready=0 throughout.
  - Toggle req_addr and req_wdata during WAIT → no effect on the response.
- Reset mid-transaction:
  - Store 0x30 = 0xCAFEF00D, then assert rst on its commit edge.
  - Load 0x30 → prior value.
  - Assert rst during RESP → resp_valid=0 next cycle.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the word-organised memory responder.
//   state_t  : responder FSM states
//   WORD_W   : data word width
//   BE_W     : byte-enable width
//   addr_err : true when a byte address is misaligned or past the last word
package mem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word storage with per-byte write enables and a registered read.
//   clk       : clock
//   en_i      : access strobe; one read (and optional write) per strobe
//   we_i      : write when 1
//   be_i      : byte lane enables for writes
//   idx_i     : word index
//   wdata_i   : write data
//   rdata_o   : word read at the last strobe (pre-write contents), held otherwise
// Contents have no reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      rdata_q <= mem_q[idx_i];
      if (we_i) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle data-side memory responder with a valid/ready request and
// response handshake, fixed access latency, byte-enable stores and an error
// response for misaligned or out-of-range addresses.
//   clk, rst                          : clock, synchronous active-high reset
//   req_valid/req_ready               : request handshake (ready only in IDLE)
//   req_wr, req_addr, req_wdata, req_be : request fields, latched on accept
//   resp_valid/resp_ready             : response handshake
//   resp_rdata, resp_err              : load data (0 for stores/errors), error flag
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
    $error("mem_responder: LATENCY must be within 1..15");
  end

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q;
  logic [31:0]       addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              err_q;
  logic              load_q;
  logic              commit;
  logic              err_now;
  logic [WORD_W-1:0] arr_rdata;

  assign err_now = addr_err(addr_q, DEPTH_WORDS);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    commit     = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = WAIT;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req_valid) begin
        wr_q    <= req_wr;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
      if (commit) begin
        err_q  <= err_now;
        load_q <= !wr_q && !err_now;
      end
    end
  end

  // Reset on the commit edge must drop the access, so the strobe is gated by rst.
  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .en_i    (commit && !err_now && !rst),
    .we_i    (wr_q),
    .be_i    (be_q),
    .idx_i   (addr_q[IDX_W+1:2]),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );

  // The array read register is only strobed at commit, so it holds steady through RESP.
  assign resp_rdata = (resp_valid && load_q) ? arr_rdata : '0;
  assign resp_err   = resp_valid && err_q;

endmodule
